shift_register: RTL and testbench

// - Parameterised shift register for the SPI-style peripheral datapath: serial-in/parallel-out (receive) and

---
 rtl/shift_register_pkg.sv | 9 +
 rtl/shift_register.sv | 53 +++++
 tb/tb_shift_register.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared constants and data-word type for the SPI shift register.
// SR_DEFAULT_WIDTH sets the default register length.
package shift_register_pkg;

  localparam int SR_DEFAULT_WIDTH = 8;

  typedef logic [SR_DEFAULT_WIDTH-1:0] sr_word_t;

endpackage

// File: rtl/shift_register.sv
// SIPO/PISO shift register advanced by a peripheral clock-edge strobe.
// Define SHIFTREG_LSB_FIRST_EN to shift LSB-first.
module shift_register
  import shift_register_pkg::*;
#(
  parameter int width = SR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             peripheralClkEdge,
  input  logic             parallelLoad,
  input  logic [width-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic [width-1:0] parallelDataOut,
  output logic             serialDataOut
);

  logic [width-1:0] mem_q;
  logic [width-1:0] mem_d;

  // Load wins over shift; nothing moves without the strobe.
  always_comb begin
    mem_d = mem_q;
    if (peripheralClkEdge) begin
      if (parallelLoad) begin
        mem_d = parallelDataIn;
      end else begin
`ifdef SHIFTREG_LSB_FIRST_EN
        mem_d = {serialDataIn, mem_q[width-1:1]};
`else
        mem_d = {mem_q[width-2:0], serialDataIn};
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign parallelDataOut = mem_q;

`ifdef SHIFTREG_LSB_FIRST_EN
  assign serialDataOut = mem_q[0];
`else
  assign serialDataOut = mem_q[width-1];
`endif

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register (width=8).
// Random stimulus against an arithmetic reference model.
module tb_shift_register;

  logic       clk;
  logic       reset;
  logic       peripheralClkEdge;
  logic       parallelLoad;
  logic [7:0] parallelDataIn;
  logic       serialDataIn;
  logic [7:0] parallelDataOut;
  logic       serialDataOut;

  int errors;
  int checks;
  int mdl;

  shift_register #(.width(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .peripheralClkEdge(peripheralClkEdge),
    .parallelLoad     (parallelLoad),
    .parallelDataIn   (parallelDataIn),
    .serialDataIn     (serialDataIn),
    .parallelDataOut  (parallelDataOut),
    .serialDataOut    (serialDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(input int m, input bit ld,
                                    input int pd, input bit sd);
    if (ld) return pd;
`ifdef SHIFTREG_LSB_FIRST_EN
    return m / 2 + 128 * int'(sd);
`else
    return (m * 2 + int'(sd)) % 256;
`endif
  endfunction

  function automatic bit model_sout(input int m);
`ifdef SHIFTREG_LSB_FIRST_EN
    return bit'(m % 2);
`else
    return bit'(m / 128);
`endif
  endfunction

  task automatic scramble();
    parallelLoad   = 1'($urandom);
    parallelDataIn = 8'($urandom);
    serialDataIn   = 1'($urandom);
  endtask

  // Idle 9 cycles with junk inputs, then a single-cycle strobe.
  task automatic pulse(input bit ld, input logic [7:0] pd,
                       input bit sd);
    repeat (9) begin
      @(negedge clk);
      scramble();
    end
    @(negedge clk);
    peripheralClkEdge = 1'b1;
    parallelLoad      = ld;
    parallelDataIn    = pd;
    serialDataIn      = sd;
    mdl = model_next(mdl, ld, int'(pd), sd);
    @(negedge clk);
    peripheralClkEdge = 1'b0;
    scramble();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset             = 1'b1;
    peripheralClkEdge = 1'b1;
    parallelLoad      = 1'b1;
    parallelDataIn    = 8'hFF;
    serialDataIn      = 1'b1;
    repeat (2) @(negedge clk);
    reset             = 1'b0;
    peripheralClkEdge = 1'b0;
    mdl = 0;
    checks++;
    if (parallelDataOut !== 8'h00) begin
      errors++;
      $display("FAIL reset_pdo got=%h exp=00", parallelDataOut);
    end
    checks++;
    if (serialDataOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_sdo got=%b exp=0", serialDataOut);
    end
  endtask

  task automatic test_serial_fill();
    for (int i = 0; i < 8; i++) pulse(1'b0, 8'h00, (i % 2) == 0);
    checks++;
    if (parallelDataOut !== 8'(mdl)) begin
      errors++;
      $display("FAIL fill_model got=%h exp=%h", parallelDataOut, 8'(mdl));
    end
`ifndef SHIFTREG_LSB_FIRST_EN
    checks++;
    if (parallelDataOut !== 8'hAA) begin
      errors++;
      $display("FAIL fill_aa got=%h exp=aa", parallelDataOut);
    end
`endif
    checks++;
    if (serialDataOut !== 1'b1) begin
      errors++;
      $display("FAIL fill_sdo got=%b exp=1", serialDataOut);
    end
  endtask

  task automatic test_load();
    pulse(1'b1, 8'hA5, 1'b1);
    checks++;
    if (parallelDataOut !== 8'hA5) begin
      errors++;
      $display("FAIL load got=%h exp=a5", parallelDataOut);
    end
    @(negedge clk);
    parallelLoad   = 1'b1;
    parallelDataIn = 8'h3C;
    repeat (5) @(negedge clk);
    checks++;
    if (parallelDataOut !== 8'hA5) begin
      errors++;
      $display("FAIL load_nostrobe got=%h exp=a5", parallelDataOut);
    end
  endtask

  task automatic test_shift_out();
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101;
    pulse(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (serialDataOut !== exp_seq[7-i]) begin
        errors++;
        $display("FAIL shift_out bit%0d got=%b exp=%b",
                 i, serialDataOut, exp_seq[7-i]);
      end
      pulse(1'b0, 8'h00, 1'b0);
    end
    checks++;
    if (parallelDataOut !== 8'h00) begin
      errors++;
      $display("FAIL shift_out_final got=%h exp=00", parallelDataOut);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [7:0] snap;
    pulse(1'b1, 8'($urandom), 1'b0);
    snap = parallelDataOut;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      scramble();
      checks++;
      if (parallelDataOut !== 8'(mdl) || parallelDataOut !== snap) begin
        errors++;
        $display("FAIL hold cyc%0d got=%h exp=%h",
                 i, parallelDataOut, 8'(mdl));
      end
    end
    for (int i = 0; i < 3; i++) pulse(1'b0, 8'h00, 1'($urandom));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl = 0;
    checks++;
    if (parallelDataOut !== 8'h00) begin
      errors++;
      $display("FAIL midword_reset got=%h exp=00", parallelDataOut);
    end
    pulse(1'b0, 8'h00, 1'b1);
    checks++;
`ifdef SHIFTREG_LSB_FIRST_EN
    if (parallelDataOut !== 8'h80) begin
      errors++;
      $display("FAIL after_reset got=%h exp=80", parallelDataOut);
    end
`else
    if (parallelDataOut !== 8'h01) begin
      errors++;
      $display("FAIL after_reset got=%h exp=01", parallelDataOut);
    end
`endif
  endtask

  task automatic test_one_shift();
    pulse(1'b1, 8'hA5, 1'b1);
    pulse(1'b0, 8'h00, 1'b0);
    checks++;
`ifdef SHIFTREG_LSB_FIRST_EN
    if (parallelDataOut !== 8'h52) begin
      errors++;
      $display("FAIL lsb_shift got=%h exp=52", parallelDataOut);
    end
`else
    if (parallelDataOut !== 8'h4A) begin
      errors++;
      $display("FAIL msb_shift got=%h exp=4a", parallelDataOut);
    end
`endif
    checks++;
    if (serialDataOut !== 1'b0) begin
      errors++;
      $display("FAIL one_shift_sdo got=%b exp=0", serialDataOut);
    end
  endtask

  task automatic test_back_to_back();
    bit sd;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      sd = 1'($urandom);
      peripheralClkEdge = 1'b1;
      parallelLoad      = (i == 0);
      parallelDataIn    = 8'($urandom);
      serialDataIn      = sd;
      mdl = model_next(mdl, parallelLoad, int'(parallelDataIn), sd);
      @(negedge clk);
      checks++;
      if (parallelDataOut !== 8'(mdl)) begin
        errors++;
        $display("FAIL b2b cyc%0d got=%h exp=%h",
                 i, parallelDataOut, 8'(mdl));
      end
    end
    peripheralClkEdge = 1'b0;
  endtask

  task automatic test_random();
    bit         ld;
    logic [7:0] pd;
    for (int i = 0; i < 150; i++) begin
      ld = ($urandom_range(0, 4) == 0);
      pd = 8'($urandom);
      pulse(ld, pd, 1'($urandom));
      checks++;
      if (parallelDataOut !== 8'(mdl) ||
          serialDataOut !== model_sout(mdl)) begin
        errors++;
        $display("FAIL random it%0d got=%h/%b exp=%h/%b", i,
                 parallelDataOut, serialDataOut, 8'(mdl), model_sout(mdl));
      end
    end
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    mdl               = 0;
    reset             = 1'b0;
    peripheralClkEdge = 1'b0;
    parallelLoad      = 1'b0;
    parallelDataIn    = 8'h00;
    serialDataIn      = 1'b0;
    test_reset();
    test_serial_fill();
    test_load();
    test_shift_out();
    test_hold_and_reset();
    test_one_shift();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
